uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one parameter: DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 i_clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_ce_x8  input  1  clock enable at 8x baud rate, single-cycle pulse per tick, from the baud generator.
REQ-005 i_rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 i_ack  input  1  consumer acknowledge; one-cycle pulse clears o_valid and o_overrun.
REQ-007 o_data  output  8  received byte, right-aligned; bits above DATA_BITS-1 SHALL be 0.
REQ-008 o_valid  output  1  o_data/o_frame_err hold a received, unacknowledged byte.
REQ-009 o_frame_err  output  1  stop bit of the byte in o_data sampled as 0.
REQ-010 o_overrun  output  1  sticky: a byte completed while o_valid=1 and was discarded.
REQ-011 o_busy  output  1  receiver state is not IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; "rx" below means the synchronized value.
REQ-013 A 3-bit tick counter SHALL advance only on i_ce_x8 cycles; ticks within a bit are numbered 0..7; no state may advance without i_ce_x8.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on an i_ce_x8 cycle with rx=0 -> START, that cycle is tick 0 of the start bit.
REQ-016 Each bit value SHALL be the majority of rx sampled at ticks 3, 4, 5; the majority is decided at tick 5.
REQ-017 START: majority 1 at tick 5 -> IDLE (false start, no outputs change); majority 0 -> continue; at tick 7 -> DATA, bit index 0.
REQ-018 DATA: at tick 7 the majority bit SHALL be shifted in LSB-first; after DATA_BITS bits -> STOP.
REQ-019 STOP: at tick 5 the frame SHALL complete: majority 1 -> IDLE; majority 0 -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until an i_ce_x8 cycle with rx=1, then -> IDLE; no start detection while in WAIT_HIGH.
REQ-021 On completion with o_valid=0, or with i_ack=1 in the same cycle: o_data and o_frame_err SHALL load and o_valid=1 on the next clock.
REQ-022 On completion with o_valid=1 and i_ack=0: new byte discarded, o_data/o_frame_err unchanged, o_overrun=1 on the next clock.
REQ-023 i_ack with no completion in the same cycle SHALL clear o_valid and o_overrun on the next clock; i_ack with o_valid=0 SHALL have no effect beyond clearing o_overrun.
REQ-024 A byte with a framing error SHALL still be delivered, with o_frame_err=1.
REQ-025 Latency: o_valid SHALL rise one i_clk after the stop-bit tick-5 i_ce_x8 cycle.
REQ-026 o_busy SHALL be combinational from state (0 only in IDLE).

Reset
REQ-027 While i_rst_n=0: state=IDLE, tick counter=0, bit index=0, shift register=0, synchronizer=1, o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, regardless of i_clk.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception restarts only from a new falling edge in IDLE.

Verification
REQ-029 i_ce_x8 every 4 clk (bit = 32 clk), frame 0x55 with stop=1 -> o_data=0x55, o_valid=1, o_frame_err=0; held until i_ack, then o_valid=0.
REQ-030 rx low for 2 i_ce_x8 ticks then high -> o_busy pulses, returns to 0 by tick 5, o_valid stays 0.
REQ-031 Frame 0xA3 with stop=0, line held low 3 bit times, then frame 0x0F -> first o_data=0xA3, o_frame_err=1; after ack, second o_data=0x0F, o_frame_err=0; no spurious byte from the low line.
REQ-032 Frames 0x12 then 0x34 with no ack -> o_data=0x12, o_overrun=1; i_ack -> o_valid=0, o_overrun=0.
REQ-033 i_ack on the exact completion cycle of 0x34 while 0x12 pending -> o_data=0x34, o_valid=1, o_overrun=0.
REQ-034 i_rst_n pulsed low at data bit 3 of a frame -> all outputs 0 immediately; next full frame 0xC6 received correctly; also DATA_BITS=5, frame 0x1B -> o_data=0x1B.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled, majority-voted bits, LSB-first, one-byte holding
// register with frame-error and sticky overrun flags.
module uart_rx #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ce_x8,
   input  logic       i_rx,
   input  logic       i_ack,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int unsigned TICK_W = 3;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t              r_state;
   logic [1:0]          r_sync;
   logic [TICK_W-1:0]   r_tick;
   logic [IDX_W-1:0]    r_bit_idx;
   logic [BYTE_W-1:0]   r_shift;
   logic                r_s3;
   logic                r_s4;
   logic                r_bit;

   logic                w_rx;
   logic                w_maj;
   logic                w_done;
   logic [BYTE_W-1:0]   w_shift_next;

   assign w_rx   = r_sync[1];
   assign w_maj  = (r_s3 & r_s4) | (r_s3 & w_rx) | (r_s4 & w_rx);
   assign w_done = i_ce_x8 && (r_state == S_STOP) && (r_tick == TICK_W'(5));
   assign o_busy = (r_state != S_IDLE);

   // New bit enters at DATA_BITS-1 so the finished word lands right-aligned.
   always_comb begin
      w_shift_next                = {1'b0, r_shift[BYTE_W-1:1]};
      w_shift_next[DATA_BITS-1]   = r_bit;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_rx};
      end
   end

   // Receive FSM; everything advances only on oversample ticks.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_s3      <= 1'b1;
         r_s4      <= 1'b1;
         r_bit     <= 1'b0;
      end else if (i_ce_x8) begin
         if (r_tick == TICK_W'(3)) r_s3 <= w_rx;
         if (r_tick == TICK_W'(4)) r_s4 <= w_rx;
         case (r_state)
            S_IDLE: begin
               if (!w_rx) begin
                  r_state   <= S_START;
                  r_tick    <= TICK_W'(1);
                  r_bit_idx <= '0;
                  r_shift   <= '0;
               end
            end
            S_START: begin
               r_tick <= r_tick + TICK_W'(1);
               if (r_tick == TICK_W'(5) && w_maj) begin
                  r_state <= S_IDLE;
                  r_tick  <= '0;
               end else if (r_tick == TICK_W'(7)) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               r_tick <= r_tick + TICK_W'(1);
               if (r_tick == TICK_W'(5)) r_bit <= w_maj;
               if (r_tick == TICK_W'(7)) begin
                  r_shift <= w_shift_next;
                  if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                     r_state   <= S_STOP;
                     r_bit_idx <= '0;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end
            end
            S_STOP: begin
               r_tick <= r_tick + TICK_W'(1);
               if (r_tick == TICK_W'(5)) begin
                  r_tick  <= '0;
                  r_state <= w_maj ? S_IDLE : S_WAIT_HIGH;
               end
            end
            S_WAIT_HIGH: begin
               if (w_rx) r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_tick  <= '0;
            end
         endcase
      end
   end

   // Holding register: a completion with ack in the same cycle counts as a free slot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else if (w_done) begin
         if (!o_valid || i_ack) begin
            o_data      <= r_shift;
            o_frame_err <= ~w_maj;
            o_valid     <= 1'b1;
            if (i_ack) o_overrun <= 1'b0;
         end else begin
            o_overrun <= 1'b1;
         end
      end else if (i_ack) begin
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end
   end

endmodule
